// File: rtl/uart_pkg.sv
// UART loopback shared definitions: RX/TX state encodings and the parity helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // Parity bit over the low nbits of dat. odd=0 gives even parity
    // (bit makes the total count of ones even), odd=1 gives odd parity.
    function automatic logic calc_parity(input logic [7:0] dat, input int nbits, input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) begin
                p = p ^ dat[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, pointers carry one extra wrap bit.
// Latency: a push is visible at the head (empty=0) the cycle after it is written.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
//
// Ports: clk, rst_n (sync, active-low); push/push_dat write side;
//        pop/head_dat read side (head_dat valid while !empty);
//        empty, full, level status.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // A pop frees the slot this cycle, so a push at full is still accepted
    // when paired with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/uart_loopback_fifo.sv
// UART receiver feeding a FIFO that drains into a UART transmitter (serial echo).
// Latency: good byte pushed 1 cycle after the stop-bit sample; TX start bit 2 cycles after push when idle.
// Backpressure: none on the line; a good byte arriving with the FIFO full is dropped and flagged on ovf.
//
// Ports: clk, rst_n (sync, active-low); uart_rx serial in (async, idle high);
//        uart_tx serial out (idle high); rx_err framing/parity pulse;
//        ovf drop pulse; fifo_level current occupancy.
module uart_loopback_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_rx,
    output logic                          uart_tx,
    output logic                          rx_err,
    output logic                          ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam int BW   = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] DIV_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);
    localparam logic          PAR_ON   = (PARITY_EN != 0);

    // ---------------- input synchronizer + edge detect ----------------
    logic rx_s1, rx_s2, rx_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // ---------------- FIFO ----------------
    logic                 rx_push;
    logic                 tx_pop;
    logic [DATA_BITS-1:0] rx_shift;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_empty;
    logic                 fifo_full;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rx_push),
        .push_dat (rx_shift),
        .pop      (tx_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .level    (fifo_level)
    );

    // ---------------- RX ----------------
    rx_state_t            rx_state, rx_state_nxt;
    logic [CW-1:0]        rx_cnt, rx_cnt_nxt;
    logic [BW-1:0]        rx_bit, rx_bit_nxt;
    logic [DATA_BITS-1:0] rx_shift_nxt;
    logic                 rx_perr, rx_perr_nxt;
    logic                 rx_wait, rx_wait_nxt;
    logic                 rx_push_nxt;
    logic                 rx_err_nxt;

    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt + 1'b1;
        rx_bit_nxt   = rx_bit;
        rx_shift_nxt = rx_shift;
        rx_perr_nxt  = rx_perr;
        rx_wait_nxt  = rx_wait;
        rx_push_nxt  = 1'b0;
        rx_err_nxt   = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                if (rx_prev && !rx_s2) begin
                    rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                // Mid start bit: a high line here was a glitch, drop it silently.
                if (rx_cnt == HALF_END) begin
                    rx_cnt_nxt  = '0;
                    rx_bit_nxt  = '0;
                    rx_perr_nxt = 1'b0;
                    rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == DIV_END) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_s2, rx_shift[DATA_BITS-1:1]};
                    rx_bit_nxt   = rx_bit + 1'b1;
                    if (rx_bit == LAST_BIT) begin
                        rx_state_nxt = PAR_ON ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_cnt == DIV_END) begin
                    rx_cnt_nxt   = '0;
                    rx_perr_nxt  = (rx_s2 != calc_parity(8'(rx_shift), DATA_BITS, PAR_ODD));
                    rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_wait) begin
                    // Framing error: hold here until the line recovers so the
                    // low stop bit cannot be taken as a new start edge.
                    rx_cnt_nxt = '0;
                    if (rx_s2) begin
                        rx_wait_nxt  = 1'b0;
                        rx_state_nxt = RX_IDLE;
                    end
                end else if (rx_cnt == DIV_END) begin
                    rx_cnt_nxt = '0;
                    if (!rx_s2 || rx_perr) begin
                        rx_err_nxt = 1'b1;
                    end else begin
                        rx_push_nxt = 1'b1;
                    end
                    if (!rx_s2) begin
                        rx_wait_nxt = 1'b1;
                    end else begin
                        rx_state_nxt = RX_IDLE;
                    end
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
            rx_wait  <= 1'b0;
            rx_push  <= 1'b0;
            rx_err   <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shift <= rx_shift_nxt;
            rx_perr  <= rx_perr_nxt;
            rx_wait  <= rx_wait_nxt;
            rx_push  <= rx_push_nxt;
            rx_err   <= rx_err_nxt;
            // Same acceptance rule as the FIFO: a same-cycle pop makes room.
            ovf      <= rx_push & fifo_full & ~tx_pop;
        end
    end

    // ---------------- TX ----------------
    tx_state_t            tx_state, tx_state_nxt;
    logic [CW-1:0]        tx_cnt, tx_cnt_nxt;
    logic [BW-1:0]        tx_bit, tx_bit_nxt;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
    logic                 tx_par, tx_par_nxt;
    logic                 tx_line_nxt;

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt + 1'b1;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
        tx_par_nxt   = tx_par;
        tx_line_nxt  = uart_tx;
        tx_pop       = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_nxt  = '0;
                tx_line_nxt = 1'b1;
                if (!fifo_empty) begin
                    tx_pop       = 1'b1;
                    tx_shift_nxt = fifo_head;
                    tx_par_nxt   = calc_parity(8'(fifo_head), DATA_BITS, PAR_ODD);
                    tx_bit_nxt   = '0;
                    tx_line_nxt  = 1'b0;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == DIV_END) begin
                    tx_cnt_nxt   = '0;
                    tx_line_nxt  = tx_shift[0];
                    tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                // tx_shift[0] is on the line; tx_shift[1] goes out next.
                if (tx_cnt == DIV_END) begin
                    tx_cnt_nxt   = '0;
                    tx_shift_nxt = tx_shift >> 1;
                    tx_bit_nxt   = tx_bit + 1'b1;
                    if (tx_bit == LAST_BIT) begin
                        if (PAR_ON) begin
                            tx_line_nxt  = tx_par;
                            tx_state_nxt = TX_PARITY;
                        end else begin
                            tx_line_nxt  = 1'b1;
                            tx_state_nxt = TX_STOP;
                        end
                    end else begin
                        tx_line_nxt = tx_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_cnt == DIV_END) begin
                    tx_cnt_nxt   = '0;
                    tx_line_nxt  = 1'b1;
                    tx_state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt == DIV_END) begin
                    tx_cnt_nxt   = '0;
                    tx_state_nxt = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_shift <= tx_shift_nxt;
            tx_par   <= tx_par_nxt;
            uart_tx  <= tx_line_nxt;
        end
    end

endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Bench for uart_loopback_fifo: four instances (8N1 default rate, 8E1, depth-4 8N1, 5N1).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_loopback_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [4];
    logic rx  [4];
    logic tx  [4];
    logic err [4];
    logic ovf [4];
    logic [4:0] lv0, lv1, lv3;
    logic [2:0] lv2;
    int lvl [4];

    always_comb begin
        lvl[0] = int'(lv0);
        lvl[1] = int'(lv1);
        lvl[2] = int'(lv2);
        lvl[3] = int'(lv3);
    end

    uart_loopback_fifo u0 (
        .clk(clk), .rst_n(rst[0]), .uart_rx(rx[0]), .uart_tx(tx[0]),
        .rx_err(err[0]), .ovf(ovf[0]), .fifo_level(lv0));

    uart_loopback_fifo #(.CLK_HZ(1600000), .BAUD(100000), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst_n(rst[1]), .uart_rx(rx[1]), .uart_tx(tx[1]),
        .rx_err(err[1]), .ovf(ovf[1]), .fifo_level(lv1));

    uart_loopback_fifo #(.CLK_HZ(800000), .BAUD(100000), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst_n(rst[2]), .uart_rx(rx[2]), .uart_tx(tx[2]),
        .rx_err(err[2]), .ovf(ovf[2]), .fifo_level(lv2));

    uart_loopback_fifo #(.CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(5)) u3 (
        .clk(clk), .rst_n(rst[3]), .uart_rx(rx[3]), .uart_tx(tx[3]),
        .rx_err(err[3]), .ovf(ovf[3]), .fifo_level(lv3));

    int n_vec = 0;
    int n_err = 0;
    longint cyc = 0;
    logic [7:0] exp_q [4][$];
    int skip2 = 0;
    int err_cnt [4] = '{default: 0};
    int ovf_cnt [4] = '{default: 0};
    int lvl_max [4] = '{default: 0};
    int nz_cnt  [4] = '{default: 0};
    int txl_cnt [4] = '{default: 0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (err[i] === 1'b1) err_cnt[i]++;
            if (ovf[i] === 1'b1) ovf_cnt[i]++;
            if (lvl[i] > lvl_max[i]) lvl_max[i] = lvl[i];
            if (lvl[i] != 0) nz_cnt[i]++;
            if (tx[i] === 1'b0) txl_cnt[i]++;
        end
    end

    function automatic int divof(input int i);
        case (i)
            0:       return 217;
            2:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int nbof(input int i);
        return (i == 3) ? 5 : 8;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input int n);
        rx[i] = v;
        repeat (n) @(negedge clk);
    endtask

    // Serial frame onto rx[i]; instance 1 carries an even parity bit.
    task automatic send_frame(input int i, input logic [7:0] d, input bit bad_par,
                              input bit bad_stop, input int stop_len);
        int dv;
        dv = divof(i);
        drive(i, 1'b0, dv);
        for (int b = 0; b < nbof(i); b++) drive(i, d[b], dv);
        if (i == 1) drive(i, (^d) ^ bad_par, dv);
        if (bad_stop) drive(i, 1'b0, 2 * dv);
        drive(i, 1'b1, stop_len);
    endtask

    task automatic wait_bits(input int i, input int n, output bit hit);
        hit = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (rst[i] !== 1'b1) hit = 1'b1;
        end
    endtask

    task automatic wait_idle(input int i);
        int k;
        k = 0;
        while (exp_q[i].size() != 0 && k < 40 * divof(i)) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("idle%0d_drained", i), exp_q[i].size(), 0);
        repeat (divof(i)) @(negedge clk);
    endtask

    // Decodes frames on tx[i] and pops the expected byte.
    task automatic monitor(input int i);
        int dv, nb;
        logic [7:0] d, e;
        logic pb, sb, st;
        bit ab, hit;
        dv = divof(i);
        nb = nbof(i);
        forever begin
            @(negedge clk);
            if (rst[i] === 1'b1 && tx[i] === 1'b0) begin
                ab = 1'b0;
                d  = '0;
                pb = 1'b0;
                wait_bits(i, dv / 2, hit); ab |= hit;
                st = tx[i];
                for (int b = 0; b < nb; b++) begin
                    wait_bits(i, dv, hit); ab |= hit;
                    d[b] = tx[i];
                end
                if (i == 1) begin
                    wait_bits(i, dv, hit); ab |= hit;
                    pb = tx[i];
                end
                wait_bits(i, dv, hit); ab |= hit;
                sb = tx[i];
                if (!ab) begin
                    chk($sformatf("tx%0d_start_bit", i), st, 0);
                    chk($sformatf("tx%0d_stop_bit", i), sb, 1);
                    if (i == 1) chk("tx1_parity", pb, ^d);
                    if (i == 2) begin
                        while (exp_q[2].size() > 0 && exp_q[2][0] != d) begin
                            void'(exp_q[2].pop_front());
                            skip2++;
                        end
                    end
                    if (exp_q[i].size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL tx%0d_unexpected: got byte %02h, none expected", i, d);
                    end else begin
                        e = exp_q[i].pop_front();
                        chk($sformatf("tx%0d_data", i), d, e);
                    end
                end
            end
        end
    endtask

    task automatic stim0;
        int dv;
        longint t0, lr, tf;
        logic [7:0] d;
        dv = divof(0);
        exp_q[0].push_back(8'h55);
        t0 = cyc;
        lr = -1;
        tf = -1;
        fork
            send_frame(0, 8'h55, 1'b0, 1'b0, dv);
            begin
                repeat (11 * dv) begin
                    @(negedge clk);
                    if (lr < 0 && lvl[0] != 0) lr = cyc;
                    if (tf < 0 && tx[0] === 1'b0) tf = cyc;
                end
            end
        join
        chk("t55_push_seen", (lr >= 0), 1);
        chk("t55_start_seen", (tf >= 0), 1);
        chk("t55_start_within_2", (tf - lr >= 0 && tf - lr <= 1), 1);
        chk("t55_after_rx_frame", (tf - t0 >= 9 * dv), 1);
        // start-bit glitch of DIV/4 cycles
        drive(0, 1'b0, dv / 4);
        drive(0, 1'b1, 2 * dv);
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom_range(0, 255));
            exp_q[0].push_back(d);
            send_frame(0, d, 1'b0, 1'b0, dv);
        end
    endtask

    task automatic stim1;
        int dv, e0, n0, t0;
        logic [7:0] d;
        dv = divof(1);
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom_range(0, 255));
            exp_q[1].push_back(d);
            send_frame(1, d, 1'b0, 1'b0, dv + int'($urandom_range(0, 5)));
        end
        wait_idle(1);
        e0 = err_cnt[1];
        n0 = nz_cnt[1];
        t0 = txl_cnt[1];
        send_frame(1, 8'hA3, 1'b1, 1'b0, dv);
        repeat (3 * dv) @(negedge clk);
        chk("par_err_one_pulse", err_cnt[1] - e0, 1);
        chk("par_err_level_zero", nz_cnt[1] - n0, 0);
        chk("par_err_tx_high", txl_cnt[1] - t0, 0);
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom_range(0, 255));
            exp_q[1].push_back(d);
            send_frame(1, d, 1'b0, 1'b0, dv);
        end
    endtask

    task automatic stim2;
        int dv;
        dv = divof(2);
        // Shortest legal stop bit: RX frames arrive slightly faster than TX drains them.
        for (int k = 0; k < 300; k++) begin
            exp_q[2].push_back(8'(k));
            send_frame(2, 8'(k), 1'b0, 1'b0, dv / 2 + 3);
        end
    endtask

    task automatic stim3;
        int dv, k;
        logic [7:0] d;
        dv = divof(3);
        exp_q[3].push_back(8'h1F);
        send_frame(3, 8'h1F, 1'b0, 1'b0, dv);
        for (int j = 0; j < 3; j++) begin
            d = 8'($urandom_range(0, 31));
            exp_q[3].push_back(d);
            send_frame(3, d, 1'b0, 1'b0, dv);
        end
        send_frame(3, 8'h0A, 1'b0, 1'b1, dv);
        wait_idle(3);
        d = 8'($urandom_range(0, 31));
        exp_q[3].push_back(d);
        fork
            send_frame(3, d, 1'b0, 1'b0, dv);
            begin
                k = 0;
                while (tx[3] !== 1'b0 && k < 12 * dv) begin
                    @(negedge clk);
                    k++;
                end
                chk("rst_tx_started", (tx[3] === 1'b0), 1);
                repeat (dv + dv / 2) @(negedge clk);
                @(posedge clk);
                #1 rst[3] = 1'b0;
                @(posedge clk);
                #1 rst[3] = 1'b1;
                @(negedge clk);
                chk("rst_mid_tx_line_high", tx[3], 1);
                chk("rst_mid_tx_level_zero", lvl[3], 0);
                exp_q[3].delete();
            end
        join
        wait_idle(3);
        d = 8'($urandom_range(0, 31));
        exp_q[3].push_back(d);
        send_frame(3, d, 1'b0, 1'b0, dv);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b0;
            rx[i]  = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset%0d_tx", i), tx[i], 1);
            chk($sformatf("reset%0d_rx_err", i), err[i], 0);
            chk($sformatf("reset%0d_ovf", i), ovf[i], 0);
            chk($sformatf("reset%0d_level", i), lvl[i], 0);
        end
        for (int i = 0; i < 4; i++) rst[i] = 1'b1;
        repeat (2) @(negedge clk);
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
        join_none
        fork
            stim0();
            stim1();
            stim2();
            stim3();
        join
        for (int k = 0; k < 20000; k++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
                exp_q[3].size() == 0 && lvl[2] == 0) break;
            @(negedge clk);
        end
        repeat (12 * 217) @(negedge clk);
        chk("q0_empty", exp_q[0].size(), 0);
        chk("q1_empty", exp_q[1].size(), 0);
        chk("q3_empty", exp_q[3].size(), 0);
        chk("ovf_matches_drops", ovf_cnt[2], skip2 + exp_q[2].size());
        chk("ovf_at_least_two", (ovf_cnt[2] >= 2), 1);
        chk("depth4_level_max", lvl_max[2], 4);
        chk("depth16_level_bound", (lvl_max[0] <= 16 && lvl_max[1] <= 16 && lvl_max[3] <= 16), 1);
        chk("rx_err_count0", err_cnt[0], 0);
        chk("rx_err_count1", err_cnt[1], 1);
        chk("rx_err_count2", err_cnt[2], 0);
        chk("rx_err_count3", err_cnt[3], 1);
        chk("ovf_count_others", ovf_cnt[0] + ovf_cnt[1] + ovf_cnt[3], 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_loopback_fifo.md
UART_LOOPBACK_FIFO -- requirements
Module: uart_loopback_fifo

Interface
REQ-001 Parameter CLK_HZ, default 25000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, legal range 5..8, payload bits per frame.
REQ-004 Parameter PARITY_EN, default 0, 1 = one parity bit after data.
REQ-005 Parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-006 Parameter FIFO_DEPTH, default 16, power of two, 2..256.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst_n  in  1  reset, synchronous and active-low.
REQ-009 uart_rx  in  1  asynchronous serial input, idle high.
REQ-010 uart_tx  out  1  serial output, idle high.
REQ-011 rx_err  out  1  one-cycle pulse on framing or parity error.
REQ-012 ovf  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-013 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 Bit period DIV SHALL be round(CLK_HZ/BAUD), computed at elaboration; DIV=217 at defaults.
REQ-015 uart_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-016 RX FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE->START on a synchronized high-to-low edge.
- In START, the line is resampled at DIV/2; if high, return to IDLE (glitch reject, no error).
REQ-017 RX SHALL sample data at DIV intervals from the start-bit midpoint, LSB first, for DATA_BITS bits; then the parity bit (if enabled); then the stop bit.
REQ-018 Stop bit sampled low -> byte discarded, rx_err pulses; FSM waits for the line to be high before returning to IDLE.
REQ-019 Parity mismatch -> byte discarded, rx_err pulses; framing and parity error in the same frame give one pulse only.
REQ-020 A good byte SHALL be pushed into the FIFO in the cycle after the stop-bit sample; bits above DATA_BITS are zero.
REQ-021 FIFO full at push time and no pop in the same cycle -> byte dropped, ovf pulses, level unchanged.
- Simultaneous push and pop at full -> both accepted, level unchanged, no ovf.
REQ-022 TX FSM states: IDLE, START, DATA, PARITY, STOP, each lasting DIV cycles except IDLE.
- In IDLE with FIFO non-empty: pop and enter START in the next cycle; uart_tx goes low at the START entry.
REQ-023 TX SHALL send DATA_BITS LSB first, then the parity bit (if enabled), then one stop bit high.
- TX SHALL return to IDLE for at least one cycle before the next pop.
REQ-024 Pop is never issued when the FIFO is empty; a push to an empty FIFO is visible to TX on the next cycle.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit for full/empty discrimination.
REQ-026 fifo_level SHALL update in the cycle after push/pop and never exceed FIFO_DEPTH.

Reset
REQ-027 While rst_n=0 at a rising edge, the following SHALL hold from the next cycle, including when reset lands mid-frame:
- uart_tx=1, rx_err=0, ovf=0, fifo_level=0.
- Both FSMs in IDLE, FIFO pointers and baud counters cleared, synchronizer flops set to 1.
REQ-028 After rst_n returns high, a frame in progress on uart_rx SHALL only be received once a fresh falling edge is seen.

Structure
REQ-029 Package uart_pkg SHALL hold the RX/TX state encodings and a parity-computation function.
REQ-030 The FIFO SHALL be a sub-module, uart_sync_fifo, parameterised by width and depth; RX, TX and baud counters stay in uart_loopback_fifo.

Verification
REQ-031 Defaults: receive 0x55 with 8N1 at DIV=217 -> identical frame on uart_tx; start edge no later than 2 cycles after the FIFO push.
REQ-032 PARITY_EN=1, PARITY_ODD=0: 0xA3 sent with wrong parity -> rx_err one pulse, fifo_level stays 0, uart_tx stays high.
REQ-033 FIFO_DEPTH=4, TX held busy: 6 back-to-back bytes 0x01..0x06 -> fifo_level reaches 4, ovf pulses twice, output sequence is 0x01..0x04 plus at most the byte popped early.
REQ-034 Start-bit glitch of DIV/4 cycles low -> no push, no rx_err.
REQ-035 rst_n low for 1 cycle mid-TX data bit -> uart_tx=1 next cycle, fifo_level=0, next good byte echoed normally.
REQ-036 DATA_BITS=5: 0x1F received -> 0x1F retransmitted as 5 data bits + stop; stop framing error -> rx_err pulse.
